// File: rtl/hi_iso14443a_pkg.sv
// Shared mode encoding and width helpers for the ISO14443-A receive path.
package hi_iso14443a_pkg;

  typedef enum logic [2:0] {
    SNIFFER       = 3'b000,
    TAGSIM_LISTEN = 3'b001,
    TAGSIM_MOD    = 3'b010,
    READER_LISTEN = 3'b011,
    READER_MOD    = 3'b100
  } mode_e;

  // (2*p4 + p3) - (2*x + p1) spans +/-3*(2^ADC_W - 1), which fits in ADC_W+3 signed bits
  function automatic int filt_w(input int adc_w);
    return adc_w + 3;
  endfunction

endpackage

// File: rtl/hi_iso14443a_rx_edge_filter.sv
// Gaussian-derivative edge filter: four-sample history plus combinational output.
module hi_edge_filter
  import hi_iso14443a_pkg::*;
#(
  parameter int ADC_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADC_W-1:0]                  adc_d,
  output logic signed [filt_w(ADC_W)-1:0]   f
);

  logic [4:1][ADC_W-1:0] p;

  always_ff @(negedge clk) begin
    if (!rst_n) p <= '0;
    else        p <= {p[3:1], adc_d};
  end

  // Positive f marks a falling edge, negative f a rising edge.
  assign f = $signed({2'b00, p[4], 1'b0}) + $signed({3'b000, p[3]})
           - $signed({2'b00, adc_d, 1'b0}) - $signed({3'b000, p[1]});

endmodule

// File: rtl/hi_iso14443a_rx.sv
// ISO14443-A receive path: edge detector, bit packer and SSP framer towards the ARM.
module hi_iso14443a_rx
  import hi_iso14443a_pkg::*;
#(
  parameter int ADC_W       = 8,
  parameter int WIN         = 16,
  parameter int WORD_W      = 8,
  parameter int THRESH      = 5,
  parameter int RESET_PHASE = 4
) (
  input  logic             adc_clk,
  input  logic             rst_n,
  input  logic [2:0]       mod_type,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             reader_bit,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             curbit
);

  localparam int FW = filt_w(ADC_W);
  localparam int CW = $clog2(WIN * WORD_W);
  localparam int PW = $clog2(WIN);
  localparam int HW = WORD_W / 2;

  localparam logic [PW-1:0]        RP     = PW'(RESET_PHASE);
  localparam logic [PW-1:0]        HALF   = PW'(WIN / 2);
  localparam logic [CW-1:0]        FR_ON  = CW'(WIN / 2 - 1);
  localparam logic [CW-1:0]        FR_OFF = CW'(WIN / 2 - 1 + WIN);
  localparam logic signed [FW-1:0] TH_P   = FW'(THRESH);
  localparam logic signed [FW-1:0] TH_N   = -TH_P;
  localparam logic signed [FW-1:0] ZERO   = '0;

  logic [CW-1:0]        cnt;
  logic [PW-1:0]        phase;
  logic                 word_start, win_start;
  logic [2:0]           mode_q, mode_eff;
  logic signed [FW-1:0] f, fall_max, rise_min;
  logic [WORD_W-1:0]    shreg, to_arm;
  logic [HW-1:0]        rdr, tag;

  assign phase      = cnt[PW-1:0];
  assign word_start = (cnt == '0);
  assign win_start  = (phase == '0);
  // The mode is only looked at on word boundaries so a word in flight is never altered.
  assign mode_eff   = word_start ? mod_type : mode_q;

  hi_edge_filter #(.ADC_W(ADC_W)) u_filt (
    .clk   (adc_clk),
    .rst_n (rst_n),
    .adc_d (adc_d),
    .f     (f)
  );

  // Windowed detector: a bit needs both a strong fall and a strong rise.
  always_ff @(negedge adc_clk) begin
    if (!rst_n) begin
      fall_max <= '0;
      rise_min <= '0;
      curbit   <= 1'b0;
    end else if (phase == RP) begin
      curbit   <= (fall_max > TH_P) && (rise_min < TH_N);
      fall_max <= '0;
      rise_min <= '0;
    end else if (f > ZERO) begin
      if (f > fall_max) fall_max <= f;
    end else begin
      if (f < rise_min) rise_min <= f;
    end
  end

  always_ff @(negedge adc_clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= SNIFFER;
      shreg  <= '0;
      rdr    <= '0;
      tag    <= '0;
      to_arm <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      if (word_start) mode_q <= mod_type;

      if (win_start) begin
        case (mode_eff)
          READER_LISTEN: shreg <= (shreg << 1) | WORD_W'(curbit);
          SNIFFER: begin
            rdr <= (rdr << 1) | HW'(reader_bit);
            tag <= (tag << 1) | HW'(curbit);
          end
          default: ;
        endcase
      end

      // Load takes the packer contents from before this tick's capture.
      if (word_start) begin
        case (mode_eff)
          READER_LISTEN: to_arm <= shreg;
          SNIFFER:       to_arm <= {rdr, tag};
          default:       to_arm <= '0;
        endcase
      end else if (win_start) begin
        to_arm <= to_arm << 1;
      end
    end
  end

  always_ff @(negedge adc_clk) begin
    if (!rst_n) begin
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
    end else begin
      if (win_start)          ssp_clk <= 1'b1;
      else if (phase == HALF) ssp_clk <= 1'b0;

      if (cnt == FR_ON)       ssp_frame <= 1'b1;
      else if (cnt == FR_OFF) ssp_frame <= 1'b0;

      ssp_din <= to_arm[WORD_W-1];
    end
  end

endmodule

// File: tb/tb_hi_iso14443a_rx.sv
// Self-checking bench for hi_iso14443a_rx against a window-level behavioural model.
module tb_hi_iso14443a_rx;

  localparam int ADC_W = 8, WIN = 16, WORD_W = 8, THRESH = 5, RP = 4;
  localparam int WPW = WIN * WORD_W;
  localparam int N = 1024;
  localparam logic [2:0] M_SNIF = 3'b000, M_TL = 3'b001, M_TM = 3'b010,
                         M_RL = 3'b011, M_RM = 3'b100;

  logic adc_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] mod_type = M_RL;
  logic [ADC_W-1:0] adc_d = 8'd128;
  logic reader_bit = 1'b0;
  logic ssp_clk, ssp_frame, ssp_din, curbit;

  always #5 adc_clk = ~adc_clk;

  hi_iso14443a_rx #(
    .ADC_W(ADC_W), .WIN(WIN), .WORD_W(WORD_W), .THRESH(THRESH), .RESET_PHASE(RP)
  ) dut (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .mod_type   (mod_type),
    .adc_d      (adc_d),
    .reader_bit (reader_bit),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .curbit     (curbit)
  );

  int s[N];
  bit rb[N];
  logic [2:0] md[N];
  bit oc[N], ok[N], of[N], od[N];
  int vec = 0, errs = 0;

  // ---------------- reference model ----------------
  function automatic int sv(input int t);
    return (t < 0) ? 0 : s[t];
  endfunction

  function automatic int fv(input int t);
    return 2 * sv(t - 4) + sv(t - 3) - 2 * sv(t) - sv(t - 1);
  endfunction

  // Decision made at evaluation tick e, over ticks since the previous evaluation.
  function automatic bit dec(input int e);
    int hi = 0, lo = 0;
    for (int t = (e - WIN + 1 < 0) ? 0 : e - WIN + 1; t < e; t++) begin
      if (fv(t) > hi) hi = fv(t);
      if (fv(t) < lo) lo = fv(t);
    end
    return (hi > THRESH) && (lo < -THRESH);
  endfunction

  function automatic bit cb_after(input int t);
    for (int e = t; e >= 0; e--)
      if (e % WIN == RP) return dec(e);
    return 1'b0;
  endfunction

  function automatic bit cb_before(input int c);
    return (c == 0) ? 1'b0 : cb_after(c - 1);
  endfunction

  function automatic logic [7:0] exp_word(input int T);
    bit q[$], r[$], g[$];
    logic [7:0] w = 8'h00;
    for (int c = 0; c < T; c += WIN) begin
      if (md[c - c % WPW] == M_RL) q.push_back(cb_before(c));
      else if (md[c - c % WPW] == M_SNIF) begin
        r.push_back(rb[c]);
        g.push_back(cb_before(c));
      end
    end
    if (md[T] == M_RL) begin
      for (int b = 0; b < 8; b++) if (q.size() > b) w[b] = q[q.size() - 1 - b];
    end else if (md[T] == M_SNIF) begin
      for (int b = 0; b < 4; b++) begin
        if (g.size() > b) w[b]     = g[g.size() - 1 - b];
        if (r.size() > b) w[b + 4] = r[r.size() - 1 - b];
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] obs_word(input int T);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7 - j] = od[T + WIN * j + WIN / 2];
    return w;
  endfunction

  function automatic bit exp_clk(input int t);
    return (t % WIN) < WIN / 2;
  endfunction

  function automatic bit exp_frame(input int t);
    return (t % WPW) >= WIN / 2 - 1 && (t % WPW) < WIN / 2 - 1 + WIN;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_stim();
    for (int t = 0; t < N; t++) begin
      s[t] = 128; rb[t] = 1'b0; md[t] = M_RL;
    end
  endtask

  task automatic square_stim();
    for (int t = 0; t < N; t++) s[t] = ((t % 8) < 4) ? 0 : 200;
  endtask

  task automatic run(input int n, input int hold);
    rst_n = 1'b0; adc_d = 8'd128; reader_bit = 1'b0; mod_type = md[0];
    repeat (hold) @(negedge adc_clk);
    @(posedge adc_clk);
    rst_n = 1'b1;
    for (int t = 0; t < n; t++) begin
      adc_d = 8'(s[t]); reader_bit = rb[t]; mod_type = md[t];
      @(negedge adc_clk);
      #1;
      oc[t] = curbit; ok[t] = ssp_clk; of[t] = ssp_frame; od[t] = ssp_din;
      @(posedge adc_clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_stim();
    square_stim();
    run(20, 4);
    vec++;
    if (of[19] !== 1'b1) begin errs++; $display("FAIL pre_reset_frame got %0b want 1", of[19]); end
    rst_n = 1'b0;
    @(negedge adc_clk); #1;
    vec++;
    if (ssp_frame !== 1'b0) begin errs++; $display("FAIL frame_drop got %0b want 0", ssp_frame); end
    repeat (19) @(negedge adc_clk);
    #1;
    vec++;
    if ({ssp_clk, ssp_frame, ssp_din, curbit} !== 4'b0000)
      begin errs++; $display("FAIL reset_outputs got %b want 0000", {ssp_clk, ssp_frame, ssp_din, curbit}); end
    @(posedge adc_clk);
    run(40, 1);
    for (int t = 0; t < 40; t++) begin
      vec++;
      if (ok[t] !== exp_clk(t) || of[t] !== exp_frame(t)) begin
        errs++;
        $display("FAIL clk_frame t=%0d got %0b%0b want %0b%0b", t, ok[t], of[t], exp_clk(t), exp_frame(t));
      end
    end
  endtask

  task automatic test_constant();
    clear_stim();
    run(400, 4);
    for (int t = 0; t < 400; t++) begin
      vec++;
      if (oc[t] !== 1'b0) begin errs++; $display("FAIL const_curbit t=%0d got %0b want 0", t, oc[t]); end
    end
    for (int T = 0; T <= 256; T += WPW) begin
      vec++;
      if (obs_word(T) !== 8'h00 || exp_word(T) !== 8'h00)
        begin errs++; $display("FAIL const_word T=%0d got %h want 00", T, obs_word(T)); end
    end
  endtask

  task automatic test_square();
    clear_stim();
    square_stim();
    run(400, 4);
    for (int t = 0; t < 400; t++) begin
      vec++;
      if (oc[t] !== cb_after(t)) begin errs++; $display("FAIL sq_curbit t=%0d got %0b want %0b", t, oc[t], cb_after(t)); end
    end
    vec++;
    if (obs_word(128) !== exp_word(128)) begin errs++; $display("FAIL sq_word1 got %h want %h", obs_word(128), exp_word(128)); end
    vec++;
    if (obs_word(256) !== 8'hFF) begin errs++; $display("FAIL sq_word2 got %h want ff", obs_word(256)); end
  endtask

  task automatic test_threshold();
    clear_stim();
    s[38] = 130; s[39] = 129; s[40] = 130;  // |f| peaks at exactly 5
    s[70] = 130; s[71] = 130; s[72] = 130;  // |f| peaks at 6
    run(100, 4);
    vec++;
    if (oc[52] !== 1'b0) begin errs++; $display("FAIL thresh_eq got %0b want 0", oc[52]); end
    vec++;
    if (oc[84] !== 1'b1) begin errs++; $display("FAIL thresh_above got %0b want 1", oc[84]); end
    for (int t = 0; t < 100; t++) begin
      vec++;
      if (oc[t] !== cb_after(t)) begin errs++; $display("FAIL thresh_curbit t=%0d got %0b want %0b", t, oc[t], cb_after(t)); end
    end
  endtask

  task automatic test_sniffer();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    clear_stim();
    for (int t = 0; t < N; t++) md[t] = M_SNIF;
    for (int w = 0; w < 4; w++)
      for (int p = 0; p < WIN; p++) rb[(12 + w) * WIN + p] = pat[w];
    for (int k = 0; k < 3; k++) begin
      s[11 * WIN + 6 + k] = 148;
      s[13 * WIN + 6 + k] = 148;
    end
    run(400, 4);
    vec++;
    if (obs_word(256) !== 8'hB5) begin errs++; $display("FAIL sniff_word got %h want b5", obs_word(256)); end
    vec++;
    if (obs_word(128) !== exp_word(128)) begin errs++; $display("FAIL sniff_word0 got %h want %h", obs_word(128), exp_word(128)); end
  endtask

  task automatic test_mode_switch();
    clear_stim();
    square_stim();
    for (int t = 160; t < N; t++) md[t] = M_TM;
    run(400, 4);
    vec++;
    if (obs_word(128) !== 8'h3F || exp_word(128) !== 8'h3F)
      begin errs++; $display("FAIL switch_cur got %h want 3f", obs_word(128)); end
    vec++;
    if (obs_word(256) !== 8'h00) begin errs++; $display("FAIL switch_next got %h want 00", obs_word(256)); end
  endtask

  task automatic test_random();
    logic [2:0] modes[5] = '{M_SNIF, M_RL, M_TL, M_RM, M_TM};
    for (int it = 0; it < 3; it++) begin
      clear_stim();
      for (int t = 0; t < N; t++) rb[t] = 1'($urandom_range(0, 1));
      for (int w = 0; w < N / WIN; w++) begin
        int amp, ph;
        logic [2:0] m;
        amp = $urandom_range(0, 4);
        ph  = $urandom_range(0, WIN - 1);
        m   = ($urandom_range(0, 3) == 0) ? modes[$urandom_range(2, 4)] : modes[$urandom_range(0, 1)];
        for (int p = 0; p < WIN; p++) md[w * WIN + p] = m;
        for (int k = 0; k < 3; k++)
          if (w * WIN + ph + k < N) s[w * WIN + ph + k] = 128 + amp;
      end
      run(768, $urandom_range(1, 5));
      for (int t = 0; t < 768; t++) begin
        vec++;
        if (oc[t] !== cb_after(t) || ok[t] !== exp_clk(t) || of[t] !== exp_frame(t)) begin
          errs++;
          $display("FAIL rnd_tick it=%0d t=%0d got %0b%0b%0b want %0b%0b%0b", it, t,
                   oc[t], ok[t], of[t], cb_after(t), exp_clk(t), exp_frame(t));
        end
      end
      for (int T = 0; T <= 640; T += WPW) begin
        vec++;
        if (obs_word(T) !== exp_word(T))
          begin errs++; $display("FAIL rnd_word it=%0d T=%0d got %h want %h", it, T, obs_word(T), exp_word(T)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_square();
    test_threshold();
    test_sniffer();
    test_mode_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
